display_scan_receiver: RTL and testbench

- Receive-side decoder for the multiplexed 4-digit 7-segment bus driven by the filling/sealing controller: inputs are the active-low anode lines (Nac_7segmentos) and the active-low segment lines (Nout_7seg).
- Samples the bus, waits for each digit to be stable, and decodes the segment patterns back to BCD.
- Assembles a complete scan frame and publishes the bottle-dozen and cork counts as BCD and binary.
- Used as a bench monitor and as the input stage of a remote supervisory panel.

---
 rtl/display_scan_pkg.sv | 36 +++
 rtl/modulo_decodificador_7seg_bcd.sv | 34 +++
 rtl/display_scan_receiver.sv | 262 ++++++++++++++++++++++++++
 tb/tb_display_scan_receiver.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_scan_pkg.sv
// rtl/display_scan_pkg.sv - shared constants, slot map and FSM states for the 7-segment scan receiver
//
// Holds the active-high a..g patterns of the ten decimal digits (bit6 = a,
// bit0 = g), the anode slot numbering of the filling/sealing display and the
// frame assembly FSM state type.
package display_scan_pkg;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  localparam int SLOT_D_GARRAFAS = 0;
  localparam int SLOT_U_GARRAFAS = 1;
  localparam int SLOT_D_ROLHAS   = 2;
  localparam int SLOT_U_ROLHAS   = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    PUBLISH = 2'd2
  } scan_state_t;

  // tens*10 + units as tens*8 + tens*2 + units; 99 fits in 7 bits.
  function automatic logic [6:0] bcd_pair_to_bin(input logic [3:0] tens,
                                                 input logic [3:0] units);
    return {tens, 3'b000} + 7'({tens, 1'b0}) + 7'(units);
  endfunction

endpackage

// File: rtl/modulo_decodificador_7seg_bcd.sv
// rtl/modulo_decodificador_7seg_bcd.sv - combinational 7-segment to BCD decoder
//
// Inverse of the controller's BCD-to-7-segment encoder.
// Ports:
//   seg   in  7  active-high segments, bit6 = a ... bit0 = g
//   bcd   out 4  decoded digit (0 when the pattern is not a digit)
//   valid out 1  pattern is one of the ten digit patterns
module modulo_decodificador_7seg_bcd
  import display_scan_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       valid
);

  always_comb begin
    bcd   = 4'd0;
    valid = 1'b1;
    case (seg)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/display_scan_receiver.sv
// rtl/display_scan_receiver.sv - receive-side decoder for the multiplexed 4-digit 7-segment bus
//
// Samples the anode/segment bus, accepts a digit once it has been stable for
// STABLE_CYC samples, assembles the four digits into a frame and publishes the
// bottle-dozen and cork counts. Optional build macro DISPLAY_SCAN_SYNC_EN puts
// a 2-flop synchronizer on both input buses (adds 2 cycles of latency).
// Ports:
//   clk            in  1  system clock, rising edge
//   Nclr           in  1  asynchronous active-low reset
//   Nac_7segmentos in  4  anode select, active-low (slot 0..3)
//   Nout_7seg      in  8  segments a..g,dp active-low (bit7..bit0)
//   garrafas_bcd   out 8  bottle-dozen count {tens,units}
//   rolhas_bcd     out 8  cork count {tens,units}
//   rolhas_bin     out 7  cork count in binary
//   frame_valid    out 1  one-cycle pulse per published frame
//   frame_changed  out 1  with frame_valid, published values changed
//   seg_err        out 1  sticky undecodable-pattern flag
//   link_lost      out 1  no digit accepted for TIMEOUT_CYC cycles
module display_scan_receiver
  import display_scan_pkg::*;
#(
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic       clk,
  input  logic       Nclr,
  input  logic [3:0] Nac_7segmentos,
  input  logic [7:0] Nout_7seg,
  output logic [7:0] garrafas_bcd,
  output logic [7:0] rolhas_bcd,
  output logic [6:0] rolhas_bin,
  output logic       frame_valid,
  output logic       frame_changed,
  output logic       seg_err,
  output logic       link_lost
);

  localparam int              TO_W        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]      STABLE_LAST = 8'(STABLE_CYC - 1);
  localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TO_MAX      = TO_W'(TIMEOUT_CYC);

  // ---------------------------------------------------------------------------
  // Input stage
  // ---------------------------------------------------------------------------
  logic [3:0] nac_s;
  logic [7:0] nout_s;

`ifdef DISPLAY_SCAN_SYNC_EN
  logic [3:0] nac_m;
  logic [7:0] nout_m;

  // Reset to all-ones so the synchronizer presents an inactive bus.
  always_ff @(posedge clk or negedge Nclr) begin
    if (!Nclr) begin
      nac_m  <= '1;
      nac_s  <= '1;
      nout_m <= '1;
      nout_s <= '1;
    end else begin
      nac_m  <= Nac_7segmentos;
      nac_s  <= nac_m;
      nout_m <= Nout_7seg;
      nout_s <= nout_m;
    end
  end
`else
  assign nac_s  = Nac_7segmentos;
  assign nout_s = Nout_7seg;
`endif

  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp_unused;
  logic [10:0] key;

  assign anode     = ~nac_s;
  assign seg       = ~nout_s[7:1];
  assign dp_unused = nout_s[0];
  assign key       = {anode, seg};

  // ---------------------------------------------------------------------------
  // Stability filter
  // ---------------------------------------------------------------------------
  logic [10:0] prev_key;
  logic [7:0]  stable_cnt;
  logic [7:0]  stable_cnt_next;
  logic        onehot;
  logic        evaluate;

  assign onehot = $onehot(anode);

  // The counter stops at STABLE_CYC-1 so a held digit is evaluated exactly
  // once; a new key restarts it at 0. Since prev_key always records the raw
  // sample, returning from a non-one-hot gap always looks like a new key.
  always_comb begin
    stable_cnt_next = stable_cnt;
    evaluate        = 1'b0;
    if (!onehot) begin
      stable_cnt_next = '0;
    end else if (key != prev_key) begin
      stable_cnt_next = '0;
      evaluate        = (STABLE_LAST == 8'd0);
    end else if (stable_cnt < STABLE_LAST) begin
      stable_cnt_next = stable_cnt + 8'd1;
      evaluate        = (stable_cnt_next == STABLE_LAST);
    end
  end

  logic [3:0] dec_bcd;
  logic       dec_valid;

  modulo_decodificador_7seg_bcd u_dec (
    .seg   (seg),
    .bcd   (dec_bcd),
    .valid (dec_valid)
  );

  logic       accept;
  logic       bad_pattern;
  logic [1:0] slot;

  assign accept      = evaluate && dec_valid;
  assign bad_pattern = evaluate && !dec_valid;

  always_comb begin
    slot = 2'd0;
    case (anode)
      4'b0001: slot = 2'(SLOT_D_GARRAFAS);
      4'b0010: slot = 2'(SLOT_U_GARRAFAS);
      4'b0100: slot = 2'(SLOT_D_ROLHAS);
      4'b1000: slot = 2'(SLOT_U_ROLHAS);
      default: slot = 2'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame assembly FSM
  // ---------------------------------------------------------------------------
  scan_state_t     state;
  scan_state_t     state_next;
  logic [3:0]      mask;
  logic [3:0]      mask_next;
  logic [3:0]      digit      [4];
  logic [3:0]      digit_next [4];
  logic [TO_W-1:0] to_cnt;
  logic            seen;
  logic            to_run;
  logic            timeout;
  logic            publish;
  logic [7:0]      new_garrafas;
  logic [7:0]      new_rolhas;

  // The timeout counter is frozen during the single PUBLISH cycle and never
  // runs before the first digit after reset.
  assign to_run  = seen && (state != PUBLISH);
  assign timeout = to_run && !accept && (to_cnt == TO_LAST);

  always_comb begin
    state_next = state;
    mask_next  = mask;
    publish    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      digit_next[i] = digit[i];
    end
    if (accept) begin
      digit_next[slot] = dec_bcd;
    end

    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SCAN;
          mask_next  = anode;
        end
      end
      SCAN: begin
        if (accept) begin
          mask_next = mask | anode;
        end
        if (timeout) begin
          state_next = IDLE;
          mask_next  = '0;
        end else if (mask_next == 4'b1111) begin
          // Go straight to PUBLISH on the completing digit so frame_valid
          // follows the fourth acceptance by one cycle.
          state_next = PUBLISH;
          publish    = 1'b1;
        end
      end
      PUBLISH: begin
        state_next = SCAN;
        mask_next  = accept ? anode : 4'b0000;
      end
      default: begin
        state_next = IDLE;
        mask_next  = '0;
      end
    endcase
  end

  assign new_garrafas = {digit_next[SLOT_D_GARRAFAS], digit_next[SLOT_U_GARRAFAS]};
  assign new_rolhas   = {digit_next[SLOT_D_ROLHAS], digit_next[SLOT_U_ROLHAS]};

  always_ff @(posedge clk or negedge Nclr) begin
    if (!Nclr) begin
      state      <= IDLE;
      mask       <= '0;
      prev_key   <= '0;
      stable_cnt <= '0;
      to_cnt     <= '0;
      seen       <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        digit[i] <= '0;
      end
    end else begin
      state      <= state_next;
      mask       <= mask_next;
      prev_key   <= key;
      stable_cnt <= stable_cnt_next;
      for (int i = 0; i < 4; i++) begin
        digit[i] <= digit_next[i];
      end
      if (accept) begin
        to_cnt <= '0;
        seen   <= 1'b1;
      end else if (to_run && (to_cnt != TO_MAX)) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge Nclr) begin
    if (!Nclr) begin
      garrafas_bcd  <= '0;
      rolhas_bcd    <= '0;
      rolhas_bin    <= '0;
      frame_valid   <= 1'b0;
      frame_changed <= 1'b0;
      seg_err       <= 1'b0;
      link_lost     <= 1'b0;
    end else begin
      frame_valid   <= publish;
      frame_changed <= publish &&
                       ((new_garrafas != garrafas_bcd) || (new_rolhas != rolhas_bcd));
      if (publish) begin
        garrafas_bcd <= new_garrafas;
        rolhas_bcd   <= new_rolhas;
        rolhas_bin   <= bcd_pair_to_bin(new_rolhas[7:4], new_rolhas[3:0]);
      end
      if (bad_pattern) begin
        seg_err <= 1'b1;
      end
      if (accept) begin
        link_lost <= 1'b0;
      end else if (timeout) begin
        link_lost <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_receiver.sv
// tb/tb_display_scan_receiver.sv - self-checking bench for display_scan_receiver
module tb_display_scan_receiver;

  localparam int SC = 4;
  localparam int TO = 50;

  logic       clk = 1'b0;
  logic       Nclr = 1'b0;
  logic [3:0] Nac_7segmentos = 4'hF;
  logic [7:0] Nout_7seg = 8'hFF;
  logic [7:0] garrafas_bcd;
  logic [7:0] rolhas_bcd;
  logic [6:0] rolhas_bin;
  logic       frame_valid;
  logic       frame_changed;
  logic       seg_err;
  logic       link_lost;

  int checks = 0;
  int failures = 0;

  display_scan_receiver #(.STABLE_CYC(SC), .TIMEOUT_CYC(TO)) dut (
    .clk            (clk),
    .Nclr           (Nclr),
    .Nac_7segmentos (Nac_7segmentos),
    .Nout_7seg      (Nout_7seg),
    .garrafas_bcd   (garrafas_bcd),
    .rolhas_bcd     (rolhas_bcd),
    .rolhas_bin     (rolhas_bin),
    .frame_valid    (frame_valid),
    .frame_changed  (frame_changed),
    .seg_err        (seg_err),
    .link_lost      (link_lost)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  // Reference model: run length of identical samples, digit table lookup,
  // a set of captured slots, and a count of idle cycles since the last digit.
  int         m_run = 0;
  logic [10:0] m_last = '0;
  bit         m_have [4];
  int         m_val [4];
  int         m_idle = 0;
  bit         m_seen = 0;
  bit         m_in_pub = 0;
  logic [7:0] m_g = 0, m_r = 0;
  logic [6:0] m_b = 0;
  bit         m_fv = 0, m_fc = 0, m_err = 0, m_link = 0;
  int         m_frames = 0;
  logic [3:0] mv_an;
  logic [6:0] mv_sg;
  logic [10:0] mv_k;
  bit         mv_acc, mv_pub;
  int         mv_d, mv_sl;
  logic [7:0] mv_ng, mv_nr;

  always @(posedge clk or negedge Nclr) begin
    if (!Nclr) begin
      m_run = 0; m_last = '0; m_idle = 0; m_seen = 0; m_in_pub = 0;
      m_g = 0; m_r = 0; m_b = 0; m_fv = 0; m_fc = 0; m_err = 0; m_link = 0;
      for (int i = 0; i < 4; i++) begin m_have[i] = 0; m_val[i] = 0; end
    end else begin
      mv_an = ~Nac_7segmentos;
      mv_sg = ~Nout_7seg[7:1];
      mv_k = {mv_an, mv_sg};
      mv_acc = 0; mv_pub = 0; m_fv = 0; m_fc = 0; mv_sl = 0;
      if ($countones(mv_an) != 1) m_run = 0;
      else if (mv_k == m_last) m_run++;
      else m_run = 1;
      m_last = mv_k;
      if ($countones(mv_an) == 1 && m_run == SC) begin
        mv_d = -1;
        for (int i = 0; i < 10; i++) if (seg_tab[i] == mv_sg) mv_d = i;
        for (int i = 0; i < 4; i++) if (mv_an[i]) mv_sl = i;
        if (mv_d < 0) m_err = 1;
        else mv_acc = 1;
      end
      if (mv_acc) begin
        m_val[mv_sl] = mv_d; m_have[mv_sl] = 1;
        m_idle = 0; m_seen = 1; m_link = 0;
        if (m_have[0] && m_have[1] && m_have[2] && m_have[3]) begin
          mv_ng = 8'(m_val[0] * 16 + m_val[1]);
          mv_nr = 8'(m_val[2] * 16 + m_val[3]);
          m_fc = (mv_ng != m_g) || (mv_nr != m_r);
          m_g = mv_ng; m_r = mv_nr;
          m_b = 7'(m_val[2] * 10 + m_val[3]);
          m_fv = 1; m_frames++; mv_pub = 1;
          for (int i = 0; i < 4; i++) m_have[i] = 0;
        end
      end else if (m_seen && !m_in_pub && m_idle < TO) begin
        m_idle++;
        if (m_idle == TO) begin
          m_link = 1;
          for (int i = 0; i < 4; i++) m_have[i] = 0;
        end
      end
      m_in_pub = mv_pub;
    end
  end

  // Observation: frame pulses seen and cycles where DUT and model disagree.
  int obs_frames = 0;
  bit obs_fc_last = 0;
  int mism = 0;

  always @(negedge clk) begin
    if (garrafas_bcd !== m_g || rolhas_bcd !== m_r || rolhas_bin !== m_b ||
        frame_valid !== m_fv || frame_changed !== m_fc || seg_err !== m_err ||
        link_lost !== m_link)
      mism++;
    if (frame_valid === 1'b1) begin
      obs_frames++;
      obs_fc_last = frame_changed;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_raw(input logic [3:0] an_hi, input logic [6:0] seg_hi, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      Nac_7segmentos = ~an_hi;
      Nout_7seg = {~seg_hi, 1'($urandom_range(0, 1))};
    end
  endtask

  task automatic drive_digit(input int slot, input int d, input int n);
    drive_raw(4'(1 << slot), seg_tab[d], n);
  endtask

  task automatic drive_frame(input int d0, input int d1, input int d2, input int d3);
    drive_digit(0, d0, SC); drive_digit(1, d1, SC);
    drive_digit(2, d2, SC); drive_digit(3, d3, SC);
  endtask

  task automatic bus_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      Nac_7segmentos = 4'hF;
      Nout_7seg = 8'hFF;
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    Nclr = 1'b0;
    settle(3);
    checks++; if (garrafas_bcd !== 8'h00) begin failures++; $display("FAIL reset_garrafas got=%h exp=00", garrafas_bcd); end
    checks++; if (rolhas_bcd !== 8'h00) begin failures++; $display("FAIL reset_rolhas got=%h exp=00", rolhas_bcd); end
    checks++; if (rolhas_bin !== 7'd0) begin failures++; $display("FAIL reset_bin got=%0d exp=0", rolhas_bin); end
    checks++; if (frame_valid !== 1'b0 || frame_changed !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", frame_valid, frame_changed); end
    checks++; if (seg_err !== 1'b0 || link_lost !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", seg_err, link_lost); end
    @(negedge clk);
    Nclr = 1'b1;
  endtask

  task automatic test_basic_frame;
    int f0 = obs_frames;
    int m0 = mism;
    drive_frame(0, 3, 4, 7);
    @(negedge clk);
    checks++; if (frame_valid !== 1'b1) begin failures++; $display("FAIL basic_latency frame_valid got=%b exp=1", frame_valid); end
    checks++; if (frame_changed !== 1'b1) begin failures++; $display("FAIL basic_changed got=%b exp=1", frame_changed); end
    @(negedge clk);
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL basic_pulse_width got=%b exp=0", frame_valid); end
    settle(2);
    checks++; if (obs_frames - f0 !== 1) begin failures++; $display("FAIL basic_frames got=%0d exp=1", obs_frames - f0); end
    checks++; if (garrafas_bcd !== 8'h03) begin failures++; $display("FAIL basic_garrafas got=%h exp=03", garrafas_bcd); end
    checks++; if (rolhas_bcd !== 8'h47) begin failures++; $display("FAIL basic_rolhas got=%h exp=47", rolhas_bcd); end
    checks++; if (rolhas_bin !== 7'd47) begin failures++; $display("FAIL basic_bin got=%0d exp=47", rolhas_bin); end
    checks++; if (mism - m0 !== 0) begin failures++; $display("FAIL basic_model mismatching_cycles=%0d exp=0", mism - m0); end
  endtask

  task automatic test_repeat_and_change;
    int f0 = obs_frames;
    int m0 = mism;
    drive_frame(0, 3, 4, 7);
    settle(2);
    checks++; if (obs_frames - f0 !== 1 || obs_fc_last !== 1'b0) begin failures++; $display("FAIL repeat_unchanged frames=%0d changed=%b exp=1,0", obs_frames - f0, obs_fc_last); end
    drive_frame(0, 3, 4, 8);
    settle(2);
    checks++; if (obs_frames - f0 !== 2 || obs_fc_last !== 1'b1) begin failures++; $display("FAIL change_flag frames=%0d changed=%b exp=2,1", obs_frames - f0, obs_fc_last); end
    checks++; if (rolhas_bin !== 7'd48 || rolhas_bcd !== 8'h48) begin failures++; $display("FAIL change_value bin=%0d bcd=%h exp=48,48", rolhas_bin, rolhas_bcd); end
    checks++; if (mism - m0 !== 0) begin failures++; $display("FAIL repeat_model mismatching_cycles=%0d exp=0", mism - m0); end
  endtask

  task automatic test_short_hold;
    int f0 = obs_frames;
    int m0 = mism;
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < 4; s++) drive_digit(s, (s + 5 * r) % 10, SC - 1);
    drive_raw(4'b0011, seg_tab[8], 10);
    bus_idle(2);
    settle(2);
    checks++; if (obs_frames - f0 !== 0) begin failures++; $display("FAIL short_hold_frames got=%0d exp=0", obs_frames - f0); end
    checks++; if (seg_err !== 1'b0) begin failures++; $display("FAIL short_hold_seg_err got=%b exp=0", seg_err); end
    checks++; if (mism - m0 !== 0) begin failures++; $display("FAIL short_hold_model mismatching_cycles=%0d exp=0", mism - m0); end
  endtask

  task automatic test_seg_err;
    int f0 = obs_frames;
    int m0 = mism;
    drive_raw(4'b0100, 7'b1001001, SC);
    @(negedge clk);
    checks++; if (seg_err !== 1'b1) begin failures++; $display("FAIL seg_err_set got=%b exp=1", seg_err); end
    drive_frame(1, 2, 3, 4);
    settle(2);
    checks++; if (obs_frames - f0 !== 1 || seg_err !== 1'b1) begin failures++; $display("FAIL seg_err_sticky frames=%0d seg_err=%b exp=1,1", obs_frames - f0, seg_err); end
    checks++; if (mism - m0 !== 0) begin failures++; $display("FAIL seg_err_model mismatching_cycles=%0d exp=0", mism - m0); end
    @(negedge clk);
    #2 Nclr = 1'b0;
    #1;
    checks++; if (seg_err !== 1'b0 || garrafas_bcd !== 8'h00) begin failures++; $display("FAIL seg_err_reset seg_err=%b garrafas=%h exp=0,00", seg_err, garrafas_bcd); end
    @(negedge clk);
    Nclr = 1'b1;
  endtask

  task automatic test_timeout;
    int f0;
    int m0 = mism;
    int k = 0;
    drive_frame(5, 6, 7, 8);
    settle(2);
    checks++; if (garrafas_bcd !== 8'h56 || rolhas_bcd !== 8'h78 || rolhas_bin !== 7'd78) begin failures++; $display("FAIL timeout_pre_frame got=%h %h %0d exp=56 78 78", garrafas_bcd, rolhas_bcd, rolhas_bin); end
    f0 = obs_frames;
    drive_digit(0, 9, SC);
    drive_digit(1, 2, SC);
    @(negedge clk);
    Nac_7segmentos = 4'hF;
    Nout_7seg = 8'hFF;
    while (link_lost !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k !== TO) begin failures++; $display("FAIL timeout_cycles got=%0d exp=%0d", k, TO); end
    checks++; if (garrafas_bcd !== 8'h56 || rolhas_bcd !== 8'h78) begin failures++; $display("FAIL timeout_hold got=%h %h exp=56 78", garrafas_bcd, rolhas_bcd); end
    drive_digit(3, 1, SC);
    @(negedge clk);
    checks++; if (link_lost !== 1'b0) begin failures++; $display("FAIL link_recover got=%b exp=0", link_lost); end
    drive_digit(2, 4, SC);
    settle(3);
    checks++; if (obs_frames - f0 !== 0) begin failures++; $display("FAIL timeout_mask_cleared frames=%0d exp=0", obs_frames - f0); end
    drive_digit(0, 9, SC);
    drive_digit(1, 2, SC);
    settle(2);
    checks++; if (obs_frames - f0 !== 1 || garrafas_bcd !== 8'h92 || rolhas_bcd !== 8'h41 || rolhas_bin !== 7'd41) begin failures++; $display("FAIL timeout_next_frame frames=%0d got=%h %h %0d exp=1 92 41 41", obs_frames - f0, garrafas_bcd, rolhas_bcd, rolhas_bin); end
    checks++; if (mism - m0 !== 0) begin failures++; $display("FAIL timeout_model mismatching_cycles=%0d exp=0", mism - m0); end
  endtask

  task automatic test_reset_mid_frame;
    int f0 = obs_frames;
    int m0 = mism;
    drive_digit(0, 3, SC);
    drive_digit(1, 1, SC);
    drive_digit(2, 4, SC);
    @(negedge clk);
    #2 Nclr = 1'b0;
    #1;
    checks++; if (garrafas_bcd !== 8'h00 || rolhas_bcd !== 8'h00 || rolhas_bin !== 7'd0 || link_lost !== 1'b0) begin failures++; $display("FAIL async_reset got=%h %h %0d %b exp=00 00 0 0", garrafas_bcd, rolhas_bcd, rolhas_bin, link_lost); end
    #1 Nclr = 1'b1;
    drive_digit(3, 9, SC);
    settle(4);
    checks++; if (obs_frames - f0 !== 0) begin failures++; $display("FAIL reset_partial_frames got=%0d exp=0", obs_frames - f0); end
    checks++; if (garrafas_bcd !== 8'h00 || rolhas_bcd !== 8'h00 || rolhas_bin !== 7'd0) begin failures++; $display("FAIL reset_partial_outputs got=%h %h %0d exp=00 00 0", garrafas_bcd, rolhas_bcd, rolhas_bin); end
    checks++; if (mism - m0 !== 0) begin failures++; $display("FAIL reset_partial_model mismatching_cycles=%0d exp=0", mism - m0); end
  endtask

  task automatic test_random;
    int f0 = obs_frames;
    int mf0 = m_frames;
    int m0 = mism;
    int r;
    for (int s = 0; s < 160; s++) begin
      r = $urandom_range(0, 19);
      if (r == 0) drive_raw(4'($urandom_range(0, 15)), 7'($urandom), $urandom_range(1, 8));
      else if (r == 1) drive_raw(4'(1 << $urandom_range(0, 3)), 7'($urandom), $urandom_range(3, 6));
      else if (r == 2) bus_idle($urandom_range(1, 70));
      else drive_digit($urandom_range(0, 3), $urandom_range(0, 9), $urandom_range(2, 6));
    end
    bus_idle(3);
    settle(2);
    checks++; if (obs_frames - f0 !== m_frames - mf0) begin failures++; $display("FAIL random_frames got=%0d exp=%0d", obs_frames - f0, m_frames - mf0); end
    checks++; if (seg_err !== m_err) begin failures++; $display("FAIL random_seg_err got=%b exp=%b", seg_err, m_err); end
    checks++; if (mism - m0 !== 0) begin failures++; $display("FAIL random_model mismatching_cycles=%0d exp=0", mism - m0); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_repeat_and_change();
    test_short_hold();
    test_seg_err();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
